alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Front-end sequencer for the ALU datapath. It accepts one instruction (opcode plus two 8-bit operands) per valid/ready handshake and decodes it into a unit select and a function code. It drives registered operands to the shift, arithmetic and logic units, waits a per-unit latency, then captures the selected unit result and C/N/V/Z from the output mux into result and status registers. Multi-bit shifts run as repeated single-bit passes through the shift unit, feeding each result back as the next operand.

Parameters:
SHIFT_LAT, 1, cycles the shift unit needs per single-bit pass (>=1)
ARITH_LAT, 1, cycles the arithmetic unit needs (>=1)
LOG_LAT, 1, cycles the logic unit needs (>=1)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
INSTR_VALID  input  1  instruction present
INSTR_READY  output  1  controller can accept; high only in IDLE with RST_N high
OPCODE  input  4  [3:2] unit (00 shift, 01 arith, 10 logic, 11 reserved); [1:0] function
OPA  input  8  operand A
OPB  input  8  operand B; for shifts, [2:0] = shift count
UNIT_A  output  8  registered operand A to units
UNIT_B  output  8  registered operand B to units
FUNC  output  2  registered function code to units
SEL  output  2  registered unit select to output mux
CIout  input  8  selected unit result from output mux
C  input  1  carry from mux
N  input  1  negative from mux
V  input  1  overflow from mux
Z  input  1  zero from mux
RESULT  output  8  captured result
FLAGS  output  4  captured flags: [0]=C [1]=N [2]=V [3]=Z
RES_VALID  output  1  one-cycle completion pulse
ERR  output  1  high with RES_VALID for a reserved opcode
BUSY  output  1  high whenever state != IDLE

Behaviour:
- Reset, asynchronous on RST_N low:
  - state = IDLE.
  - UNIT_A, UNIT_B, FUNC, SEL, RESULT, FLAGS, RES_VALID, ERR all = 0.
  - Internal latency and shift counters = 0.
  - INSTR_READY = 0 while RST_N is low.
- Reset mid-operation aborts the instruction. No RES_VALID is produced, and RESULT/FLAGS clear.
- States: IDLE, EXEC, DONE.
- Accept:
  - An instruction is accepted on the rising edge where INSTR_VALID && INSTR_READY.
  - On accept: UNIT_A <= OPA, UNIT_B <= OPB, FUNC <= OPCODE[1:0], SEL <= OPCODE[3:2].
  - The latency counter loads the selected unit's LAT.
  - For shifts, the shift counter loads OPB[2:0].
- IDLE -> EXEC: on accept with unit 00, 01 or 10, except a shift with count 0.
- IDLE -> DONE (reserved opcode 11): ERR=1 next cycle. RESULT and FLAGS are unchanged. No unit is driven; SEL is still loaded to 11.
- IDLE -> DONE (shift with count 0): RESULT <= OPA and FLAGS <= {Z=(OPA==0), V=0, N=OPA[7], C=0}.
- EXEC:
  - The latency counter decrements each cycle.
  - On the cycle the counter is 1, the controller samples CIout and C/N/V/Z.
  - Arith/logic sample: RESULT <= CIout, FLAGS <= {Z,V,N,C}, then -> DONE.
  - Shift sample, shift counter > 1: UNIT_A <= CIout, shift counter decrements, latency counter reloads SHIFT_LAT, stay in EXEC.
  - Shift sample, shift counter == 1: capture RESULT/FLAGS as for arith/logic, then -> DONE. Flags are from the final pass only.
- DONE:
  - RES_VALID=1 for exactly one cycle; ERR=1 only for a reserved opcode; INSTR_READY=0.
  - Next state is IDLE.
  - RES_VALID and ERR are 0 in all other states.
- Latency from the accept edge to the RES_VALID cycle:
  - Arithmetic: ARITH_LAT+1 cycles.
  - Logic: LOG_LAT+1 cycles.
  - Shift with count k>=1: k*SHIFT_LAT+1 cycles.
  - Reserved opcode or shift count 0: 1 cycle.
- Back-to-back throughput: minimum 2 cycles between accepts (accept, DONE, IDLE accept).
- INSTR_VALID while busy is ignored. The instruction is not latched, and the source must hold it until READY.
- UNIT_A/B, FUNC and SEL hold their values after completion until the next accept.
- RESULT and FLAGS hold until the next capture.
- OPB[7:3] are passed to UNIT_B unchanged but ignored by the controller for shifts.

Test Plan:
- Reset: assert RST_N=0 mid-EXEC of an arith op -> all outputs 0 immediately, no RES_VALID; after release INSTR_READY=1, BUSY=0.
- Arith, default LATs: OPCODE=0100, OPA=8'h7F, OPB=8'h01; model returns CIout=8'h80, C=0 N=1 V=1 Z=0 -> SEL=01, FUNC=00; RES_VALID 2 cycles after accept; RESULT=8'h80, FLAGS=4'b0110.
- Shift count 3, SHIFT_LAT=2: OPCODE=0000, OPA=8'h01, OPB=8'h03; model shift-left -> UNIT_A sequence 01,02,04; RES_VALID 7 cycles after accept; RESULT=8'h08, FLAGS=4'b0000.
- Shift count 0: OPA=8'h00, OPB=8'h00 -> RES_VALID 1 cycle after accept, RESULT=8'h00, FLAGS=4'b1000, units not waited on.
- Reserved: OPCODE=1101 after a prior RESULT=8'h55 -> RES_VALID and ERR high together 1 cycle after accept; RESULT stays 8'h55.
- Busy backpressure: hold INSTR_VALID with new operands during EXEC -> INSTR_READY=0 and no re-latch of UNIT_A; the next accept happens on the IDLE cycle following DONE.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Front-end sequencer for the ALU datapath. It accepts one instruction per
// INSTR_VALID/INSTR_READY handshake and decodes it into a unit select (SEL)
// and a function code (FUNC). It drives registered operands to the units and
// waits the selected unit's latency. It then captures the unit result and the
// C/N/V/Z flags from the output mux into RESULT/FLAGS and pulses RES_VALID.
// A multi-bit shift runs as repeated single-bit passes through the shift
// unit. Each pass result is fed back onto UNIT_A as the next operand.
//
// Parameters
//   SHIFT_LAT  cycles per single-bit shift pass (>=1)
//   ARITH_LAT  cycles of the arithmetic unit    (>=1)
//   LOG_LAT    cycles of the logic unit         (>=1)
//
// Ports
//   CLK, RST_N       clock (rising edge), asynchronous active-low reset
//   INSTR_VALID/READY instruction handshake; READY only in IDLE out of reset
//   OPCODE[3:2]      unit: 00 shift, 01 arith, 10 logic, 11 reserved
//   OPCODE[1:0]      function code forwarded to the unit
//   OPA, OPB         operands; OPB[2:0] is the shift count for shifts
//   UNIT_A/B, FUNC, SEL  registered drive to the units and the output mux
//   CIout, C/N/V/Z   selected unit result and flags from the output mux
//   RESULT, FLAGS    captured result and flags {Z,V,N,C}
//   RES_VALID, ERR   one-cycle completion pulse, reserved-opcode error
//   BUSY             controller is not in IDLE
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int SHIFT_LAT = 1,
    parameter int ARITH_LAT = 1,
    parameter int LOG_LAT   = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       INSTR_VALID,
    output logic       INSTR_READY,
    input  logic [3:0] OPCODE,
    input  logic [7:0] OPA,
    input  logic [7:0] OPB,
    output logic [7:0] UNIT_A,
    output logic [7:0] UNIT_B,
    output logic [1:0] FUNC,
    output logic [1:0] SEL,
    input  logic [7:0] CIout,
    input  logic       C,
    input  logic       N,
    input  logic       V,
    input  logic       Z,
    output logic [7:0] RESULT,
    output logic [3:0] FLAGS,
    output logic       RES_VALID,
    output logic       ERR,
    output logic       BUSY
);

    // Controller states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Unit select encodings (OPCODE[3:2])
    localparam logic [1:0] UNIT_SHIFT = 2'b00;
    localparam logic [1:0] UNIT_ARITH = 2'b01;
    localparam logic [1:0] UNIT_LOGIC = 2'b10;

    // The latency counter is sized for the largest unit latency
    localparam int MAX_LAT = (SHIFT_LAT > ARITH_LAT)
                           ? ((SHIFT_LAT > LOG_LAT) ? SHIFT_LAT : LOG_LAT)
                           : ((ARITH_LAT > LOG_LAT) ? ARITH_LAT : LOG_LAT);
    localparam int LAT_W   = $clog2(MAX_LAT + 1);

    localparam logic [LAT_W-1:0] SHIFT_LAT_C = LAT_W'(SHIFT_LAT);
    localparam logic [LAT_W-1:0] ARITH_LAT_C = LAT_W'(ARITH_LAT);
    localparam logic [LAT_W-1:0] LOG_LAT_C   = LAT_W'(LOG_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE     = LAT_W'(1);
    localparam logic [LAT_W-1:0] LAT_ZERO    = LAT_W'(0);

    // Flags for a zero-count shift: the operand passes straight through
    function automatic logic [3:0] pass_flags(input logic [7:0] value);
        pass_flags = {(value == 8'h00), 1'b0, value[7], 1'b0};
    endfunction

    // State and datapath registers
    logic [1:0]       state_q,     state_d;
    logic [7:0]       unit_a_q,    unit_a_d;
    logic [7:0]       unit_b_q,    unit_b_d;
    logic [1:0]       func_q,      func_d;
    logic [1:0]       sel_q,       sel_d;
    logic [7:0]       result_q,    result_d;
    logic [3:0]       flags_q,     flags_d;
    logic             res_valid_q, res_valid_d;
    logic             err_q,       err_d;
    logic [LAT_W-1:0] lat_cnt_q,   lat_cnt_d;
    logic [2:0]       shift_cnt_q, shift_cnt_d;

    logic             accept_s;
    logic [1:0]       op_unit_s;
    logic [2:0]       op_count_s;
    logic             sample_s;
    logic             more_passes_s;

    // READY is a decode of the state register, gated so it is low during reset
    assign INSTR_READY = RST_N && (state_q == ST_IDLE);
    assign BUSY        = (state_q != ST_IDLE);

    assign UNIT_A    = unit_a_q;
    assign UNIT_B    = unit_b_q;
    assign FUNC      = func_q;
    assign SEL       = sel_q;
    assign RESULT    = result_q;
    assign FLAGS     = flags_q;
    assign RES_VALID = res_valid_q;
    assign ERR       = err_q;

    assign accept_s      = INSTR_VALID && INSTR_READY;
    assign op_unit_s     = OPCODE[3:2];
    assign op_count_s    = OPB[2:0];
    // A zero count cannot occur in EXEC; treating <=1 as "sample now" keeps
    // the counter from wrapping if it ever did.
    assign sample_s      = (lat_cnt_q <= LAT_ONE);
    assign more_passes_s = (sel_q == UNIT_SHIFT) && (shift_cnt_q > 3'd1);

    // Next-state, operand, latency and capture logic
    always_comb begin
        state_d     = state_q;
        unit_a_d    = unit_a_q;
        unit_b_d    = unit_b_q;
        func_d      = func_q;
        sel_d       = sel_q;
        result_d    = result_q;
        flags_d     = flags_q;
        lat_cnt_d   = lat_cnt_q;
        shift_cnt_d = shift_cnt_q;
        res_valid_d = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    unit_a_d = OPA;
                    unit_b_d = OPB;
                    func_d   = OPCODE[1:0];
                    sel_d    = op_unit_s;
                    case (op_unit_s)
                        UNIT_SHIFT: begin
                            lat_cnt_d   = SHIFT_LAT_C;
                            shift_cnt_d = op_count_s;
                            if (op_count_s == 3'd0) begin
                                // Nothing to shift: complete without the unit
                                result_d    = OPA;
                                flags_d     = pass_flags(OPA);
                                state_d     = ST_DONE;
                                res_valid_d = 1'b1;
                            end else begin
                                state_d = ST_EXEC;
                            end
                        end
                        UNIT_ARITH: begin
                            lat_cnt_d   = ARITH_LAT_C;
                            shift_cnt_d = 3'd0;
                            state_d     = ST_EXEC;
                        end
                        UNIT_LOGIC: begin
                            lat_cnt_d   = LOG_LAT_C;
                            shift_cnt_d = 3'd0;
                            state_d     = ST_EXEC;
                        end
                        default: begin
                            // Reserved unit: flag the error, keep RESULT/FLAGS
                            lat_cnt_d   = LAT_ZERO;
                            shift_cnt_d = 3'd0;
                            state_d     = ST_DONE;
                            res_valid_d = 1'b1;
                            err_d       = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_EXEC: begin
                if (sample_s) begin
                    if (more_passes_s) begin
                        // Feed this pass back as the operand of the next pass
                        unit_a_d    = CIout;
                        shift_cnt_d = shift_cnt_q - 3'd1;
                        lat_cnt_d   = SHIFT_LAT_C;
                        state_d     = ST_EXEC;
                    end else begin
                        result_d    = CIout;
                        flags_d     = {Z, V, N, C};
                        lat_cnt_d   = LAT_ZERO;
                        shift_cnt_d = 3'd0;
                        state_d     = ST_DONE;
                        res_valid_d = 1'b1;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_ONE;
                    state_d   = ST_EXEC;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register update with asynchronous clear
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            unit_a_q    <= 8'h00;
            unit_b_q    <= 8'h00;
            func_q      <= 2'b00;
            sel_q       <= 2'b00;
            result_q    <= 8'h00;
            flags_q     <= 4'h0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
            lat_cnt_q   <= LAT_ZERO;
            shift_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            unit_a_q    <= unit_a_d;
            unit_b_q    <= unit_b_d;
            func_q      <= func_d;
            sel_q       <= sel_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
            lat_cnt_q   <= lat_cnt_d;
            shift_cnt_q <= shift_cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Self-checking bench for alu_issue_ctrl. A behavioural ALU stands in for the
// shift/arith/logic units behind the output mux. A reference model predicts
// each instruction's latency, result, flags, error bit and the UNIT_A operand
// seen during execution. It does this from the instruction semantics alone.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    localparam int SL = 2;
    localparam int AL = 1;
    localparam int LL = 3;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] opcode;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [7:0] unit_a;
    logic [7:0] unit_b;
    logic [1:0] func;
    logic [1:0] sel;
    logic [7:0] ci_out;
    logic       c_f, n_f, v_f, z_f;
    logic [7:0] result;
    logic [3:0] flags;
    logic       res_valid;
    logic       err;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_result;
    logic [3:0] m_flags;

    alu_issue_ctrl #(
        .SHIFT_LAT (SL),
        .ARITH_LAT (AL),
        .LOG_LAT   (LL)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .INSTR_VALID (instr_valid),
        .INSTR_READY (instr_ready),
        .OPCODE      (opcode),
        .OPA         (opa),
        .OPB         (opb),
        .UNIT_A      (unit_a),
        .UNIT_B      (unit_b),
        .FUNC        (func),
        .SEL         (sel),
        .CIout       (ci_out),
        .C           (c_f),
        .N           (n_f),
        .V           (v_f),
        .Z           (z_f),
        .RESULT      (result),
        .FLAGS       (flags),
        .RES_VALID   (res_valid),
        .ERR         (err),
        .BUSY        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {Z,V,N,C, result}
    function automatic logic [11:0] alu_f(input logic [1:0] u, input logic [1:0] f,
                                          input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, v;
        c = 1'b0;
        v = 1'b0;
        r = 8'h00;
        case (u)
            2'b00: begin
                case (f)
                    2'b00:   begin r = {a[6:0], 1'b0}; c = a[7]; end
                    2'b01:   begin r = {1'b0, a[7:1]}; c = a[0]; end
                    2'b10:   begin r = {a[7], a[7:1]}; c = a[0]; end
                    default: begin r = {a[6:0], a[7]}; c = a[7]; end
                endcase
            end
            2'b01: begin
                case (f)
                    2'b00:   begin w = {1'b0, a} + {1'b0, b};
                                   v = (a[7] == b[7]) && (w[7] != a[7]); end
                    2'b01:   begin w = {1'b0, a} - {1'b0, b};
                                   v = (a[7] != b[7]) && (w[7] != a[7]); end
                    2'b10:   begin w = {1'b0, a} + 9'd1;
                                   v = (a == 8'h7F); end
                    default: begin w = {1'b0, a} - 9'd1;
                                   v = (a == 8'h80); end
                endcase
                r = w[7:0];
                c = w[8];
            end
            2'b10: begin
                case (f)
                    2'b00:   r = a & b;
                    2'b01:   r = a | b;
                    2'b10:   r = a ^ b;
                    default: r = ~a;
                endcase
            end
            default: r = 8'hEE;
        endcase
        alu_f = {(r == 8'h00), v, r[7], c, r};
    endfunction

    // Output mux model driven by the controller's registered unit inputs
    always_comb begin
        logic [11:0] o;
        o      = alu_f(sel, func, unit_a, unit_b);
        ci_out = o[7:0];
        c_f    = o[8];
        n_f    = o[9];
        v_f    = o[10];
        z_f    = o[11];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction from an IDLE cycle (posedge+1) and check it end to
    // end. With bp set, the next instruction is presented while this one runs.
    task automatic run_instr(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input bit bp, input logic [3:0] nop,
                             input logic [7:0] na, input logic [7:0] nb);
        logic [1:0]  u;
        logic [1:0]  f;
        int          k;
        int          exp_lat;
        int          cyc;
        int          rdy_bad;
        logic [7:0]  exp_res;
        logic [3:0]  exp_flg;
        logic        exp_err;
        logic [7:0]  cur;
        logic [7:0]  last_a;
        logic [11:0] r;
        logic [7:0]  exp_q[$];
        logic [7:0]  obs_q[$];

        u       = op[3:2];
        f       = op[1:0];
        exp_err = 1'b0;
        last_a  = a;
        r       = 12'h000;
        exp_q.delete();
        obs_q.delete();

        // Reference model
        case (u)
            2'b11: begin
                exp_lat = 1;
                exp_err = 1'b1;
                exp_res = m_result;
                exp_flg = m_flags;
            end
            2'b00: begin
                k = int'(b[2:0]);
                if (k == 0) begin
                    exp_lat = 1;
                    exp_res = a;
                    exp_flg = {(a == 8'h00), 1'b0, a[7], 1'b0};
                end else begin
                    cur = a;
                    for (int p = 0; p < k; p++) begin
                        for (int j = 0; j < SL; j++) exp_q.push_back(cur);
                        last_a = cur;
                        r      = alu_f(2'b00, f, cur, b);
                        cur    = r[7:0];
                    end
                    exp_res = cur;
                    exp_flg = r[11:8];
                    exp_lat = k * SL + 1;
                end
            end
            default: begin
                k = (u == 2'b01) ? AL : LL;
                for (int j = 0; j < k; j++) exp_q.push_back(a);
                r       = alu_f(u, f, a, b);
                exp_res = r[7:0];
                exp_flg = r[11:8];
                exp_lat = k + 1;
            end
        endcase
        m_result = exp_res;
        m_flags  = exp_flg;

        check_eq("idle_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("idle_busy",  {31'd0, busy}, 32'd0);

        instr_valid = 1'b1;
        opcode      = op;
        opa         = a;
        opb         = b;
        @(posedge clk);
        #1;
        if (bp) begin
            instr_valid = 1'b1;
            opcode      = nop;
            opa         = na;
            opb         = nb;
        end else begin
            instr_valid = 1'b0;
        end

        check_eq("acc_sel",   {30'd0, sel},  {30'd0, u});
        check_eq("acc_func",  {30'd0, func}, {30'd0, f});
        check_eq("acc_unitb", {24'd0, unit_b}, {24'd0, b});
        check_eq("acc_unita", {24'd0, unit_a}, {24'd0, a});

        cyc     = 1;
        rdy_bad = 0;
        while (res_valid !== 1'b1 && cyc < 64) begin
            obs_q.push_back(unit_a);
            if (instr_ready !== 1'b0) rdy_bad++;
            if (err !== 1'b0) rdy_bad++;
            @(posedge clk);
            #1;
            cyc++;
        end

        check_eq("latency",   cyc, exp_lat);
        check_eq("res_valid", {31'd0, res_valid}, 32'd1);
        check_eq("err",       {31'd0, err}, {31'd0, exp_err});
        check_eq("result",    {24'd0, result}, {24'd0, exp_res});
        check_eq("flags",     {28'd0, flags}, {28'd0, exp_flg});
        check_eq("done_ready", {31'd0, instr_ready}, 32'd0);
        check_eq("done_busy",  {31'd0, busy}, 32'd1);
        check_eq("exec_ready_err", rdy_bad, 0);
        check_eq("unita_len", obs_q.size(), exp_q.size());
        if (obs_q.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++)
                check_eq($sformatf("unita_seq%0d", i), {24'd0, obs_q[i]}, {24'd0, exp_q[i]});
        end

        @(posedge clk);
        #1;
        check_eq("post_valid",  {31'd0, res_valid}, 32'd0);
        check_eq("post_err",    {31'd0, err}, 32'd0);
        check_eq("post_ready",  {31'd0, instr_ready}, 32'd1);
        check_eq("post_busy",   {31'd0, busy}, 32'd0);
        check_eq("post_result", {24'd0, result}, {24'd0, exp_res});
        check_eq("post_unita",  {24'd0, unit_a}, {24'd0, last_a});
        check_eq("post_sel",    {30'd0, sel}, {30'd0, u});
    endtask

    logic [3:0] r_op [0:40];
    logic [7:0] r_a  [0:40];
    logic [7:0] r_b  [0:40];

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        opcode      = 4'h0;
        opa         = 8'h00;
        opb         = 8'h00;
        m_result    = 8'h00;
        m_flags     = 4'h0;

        #2;
        check_eq("rst_ready",  {31'd0, instr_ready}, 32'd0);
        check_eq("rst_busy",   {31'd0, busy}, 32'd0);
        check_eq("rst_result", {24'd0, result}, 32'd0);
        check_eq("rst_flags",  {28'd0, flags}, 32'd0);
        check_eq("rst_valid",  {31'd0, res_valid}, 32'd0);
        check_eq("rst_unita",  {24'd0, unit_a}, 32'd0);
        check_eq("rst_sel",    {30'd0, sel}, 32'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Arithmetic: 7F + 01 -> 80, N and V set
        run_instr(4'b0100, 8'h7F, 8'h01, 1'b0, 4'h0, 8'h00, 8'h00);
        check_eq("tp_arith_res",   {24'd0, result}, 32'h80);
        check_eq("tp_arith_flags", {28'd0, flags}, 32'h6);

        // Shift left by 3 through single-bit passes
        run_instr(4'b0000, 8'h01, 8'h03, 1'b0, 4'h0, 8'h00, 8'h00);
        check_eq("tp_shift_res",   {24'd0, result}, 32'h08);
        check_eq("tp_shift_flags", {28'd0, flags}, 32'h0);

        // Zero-count shift completes without waiting on the unit
        run_instr(4'b0000, 8'h00, 8'h00, 1'b0, 4'h0, 8'h00, 8'h00);
        check_eq("tp_shift0_flags", {28'd0, flags}, 32'h8);

        // Reserved opcode keeps the previous result
        run_instr(4'b1001, 8'h50, 8'h05, 1'b0, 4'h0, 8'h00, 8'h00);
        run_instr(4'b1101, 8'hAA, 8'h33, 1'b0, 4'h0, 8'h00, 8'h00);
        check_eq("tp_rsvd_res", {24'd0, result}, 32'h55);

        // Backpressure: next instruction held valid while busy
        run_instr(4'b1000, 8'h3C, 8'h0F, 1'b1, 4'b1010, 8'hF0, 8'h0F);
        run_instr(4'b1010, 8'hF0, 8'h0F, 1'b1, 4'b0001, 8'h81, 8'h05);
        run_instr(4'b0001, 8'h81, 8'h05, 1'b0, 4'h0, 8'h00, 8'h00);

        // Randomized instructions, half of them under backpressure
        for (int i = 0; i <= 40; i++) begin
            r_op[i] = 4'($urandom_range(0, 15));
            r_a[i]  = 8'($urandom);
            r_b[i]  = 8'($urandom);
        end
        for (int i = 0; i < 40; i++) begin
            run_instr(r_op[i], r_a[i], r_b[i], 1'($urandom_range(0, 1)),
                      r_op[i+1], r_a[i+1], r_b[i+1]);
        end

        // Reset in the middle of an arithmetic operation
        run_instr(4'b0100, 8'h10, 8'h20, 1'b0, 4'h0, 8'h00, 8'h00);
        instr_valid = 1'b1;
        opcode      = 4'b0100;
        opa         = 8'h01;
        opb         = 8'h01;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        check_eq("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mrst_result", {24'd0, result}, 32'd0);
        check_eq("mrst_flags",  {28'd0, flags}, 32'd0);
        check_eq("mrst_unita",  {24'd0, unit_a}, 32'd0);
        check_eq("mrst_unitb",  {24'd0, unit_b}, 32'd0);
        check_eq("mrst_func",   {30'd0, func}, 32'd0);
        check_eq("mrst_sel",    {30'd0, sel}, 32'd0);
        check_eq("mrst_ready",  {31'd0, instr_ready}, 32'd0);
        check_eq("mrst_busy",   {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("mrst_valid", {31'd0, res_valid}, 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rel_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("rel_busy",  {31'd0, busy}, 32'd0);
        m_result = 8'h00;
        m_flags  = 4'h0;
        run_instr(4'b0101, 8'h05, 8'h07, 1'b0, 4'h0, 8'h00, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
